coeff_unpack_decompress: RTL and testbench
==========================================

# coeff_unpack_decompress

Consumes the 64-bit packed coefficient words produced by the ByteDecode stage and splits them into individual d-bit fields. It applies Kyber Decompress_d (d = 12: reduce mod q) and streams one 12-bit coefficient per cycle to the polynomial/NTT datapath. It handles the d-bit fields that straddle 64-bit word boundaries, applies backpressure upstream, and counts exactly 256 coefficients per polynomial.

## Interface
- Q, 3329: Kyber modulus.
- N, 256: coefficients per polynomial.
- W, 64: input word width.
- i_clk  in  1  clock. One clock domain; reset is asynchronous and active-low.
- i_rstn  in  1  asynchronous active-low reset.
- i_start  in  1  start pulse; sampled in S_IDLE only.
- i_l  in  4  field width d, sampled on the accepted i_start; legal values are 1, 4, 5, 10, 11, 12.
- i_coeffs  in  64  packed word. Stream bit 64w+b is i_coeffs[b] of word w.
- i_coeffs_valid  in  1  input word valid.
- o_coeffs_ready  out  1  input word accepted when valid && ready.
- o_coeff  out  12  decompressed coefficient, in [0, Q-1].
- o_coeff_valid  out  1  output valid.
- i_coeff_ready  in  1  downstream ready.
- o_idx  out  8  index of the coefficient currently on o_coeff.
- o_busy  out  1  high in S_RUN.
- o_done  out  1  one-cycle pulse after the 256th output handshake.

## Operation
- Field format: coefficient k has bit j at stream bit k*d+j, LSB-first. One polynomial is exactly 4*d words.
- FSM:
  - S_IDLE -> S_RUN on i_start with a legal i_l. Latch d, clear counters and buffer.
  - On i_start with an illegal i_l, stay in S_IDLE with no outputs.
  - S_RUN -> S_DONE when the 256th coefficient handshakes.
  - S_DONE -> S_IDLE unconditionally. o_done = 1 only in S_DONE.
- Bit buffer: 128-bit register plus an 8-bit fill count (0..128). Valid bits sit at [fill-1:0]. The oldest bit is bit 0.
- o_coeffs_ready = S_RUN && fill <= 64 && words_in < 4*d. This uses registered fill only. Words beyond 4*d are never accepted.
- Extraction fires when fill >= d && (!o_coeff_valid || i_coeff_ready) && coeffs_out < 256.
  - raw = buf[d-1:0].
  - The buffer shifts right by d.
- Simultaneous accept and extract:
  - The new word lands at bit position fill - d, after the shift.
  - fill_next = fill + 64 - d.
- Accept alone: the word lands at bit position fill; fill_next = fill + 64.
- Decompress, all arithmetic unsigned:
  - d < 12: y = (raw*3329 + 2^(d-1)) >> d, with a 23-bit intermediate.
  - d = 12: y = raw >= 3329 ? raw - 3329 : raw.
- o_coeff and o_idx are registered on extraction. o_coeff_valid holds until handshake.
- Outputs are stable while valid && !ready.
- Reset values: o_coeff = 0, o_coeff_valid = 0, o_coeffs_ready = 0, o_idx = 0, o_busy = 0, o_done = 0, state S_IDLE, fill = 0.
- Reset mid-operation: everything returns to the reset values immediately. Partial data is discarded.
- i_start during S_RUN or S_DONE is ignored.

## Timing
- Word accepted at edge t. The first coefficient from it is valid in cycle t+1 (buffer write), output register loaded at edge t+1, so it is visible after edge t+1.
- The start-to-first-word-ready delay is 1 cycle: o_coeffs_ready rises in the first S_RUN cycle.
- Sustained output is 1 coefficient/cycle for every d, provided upstream supplies words whenever ready.
  - d = 12: a word is needed every 5.33 cycles.
  - d = 1: a word is needed every 64 cycles.
- The o_done pulse occurs in the cycle after the last handshake. o_coeff_valid is 0 in that cycle.

## Structure
- Shared package kyber_pkg holds:
  - KYBER_Q = 3329, KYBER_N = 256.
  - State encodings S_IDLE/S_RUN/S_DONE.
  - The legal-d check function.
  - Words-per-polynomial = 4*d.
- Sub-module decompress_round: combinational, inputs raw[11:0] and d[3:0], output y[11:0]. It holds the multiply/round and the mod-q subtract. It is reused by the compress/decompress test model.

## Test plan
- d = 1, 4 words of all-ones, i_coeff_ready = 1 -> 256 outputs of 1665, indices 0..255 consecutive. Then o_done pulses once and o_coeffs_ready never rises after the 4th word.
- d = 4, word 0 = 64'hFEDCBA9876543210 -> first 16 outputs are decompress_4 of 0..15: 0, 208, 416, ..., 3121.
- d = 11, stream of all-ones (44 words) -> every output is 3327, including coefficients 5 and 11, whose fields cross word boundaries at bits 55..65 and 121..131.
- d = 12, fields 3328, 3329, 4095, 0 -> outputs 3328, 0, 766, 0.
- d = 10 with i_coeff_ready toggling at random and gaps in i_coeffs_valid -> o_coeff is stable while stalled, no loss or duplication, and exactly 256 outputs.
- Illegal i_l = 7 with i_start -> stays in S_IDLE, o_busy = 0. A separate case: i_rstn pulled low at coefficient 100 of a d = 5 run -> all outputs at reset values; a new i_start then runs cleanly from index 0.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants, coefficient-unpacker FSM states and field-width helpers.
package kyber_pkg;

  localparam int unsigned KYBER_Q = 3329;
  localparam int unsigned KYBER_N = 256;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } unpack_state_e;

  function automatic logic legal_d(input logic [3:0] d);
    case (d)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: legal_d = 1'b1;
      default:                               legal_d = 1'b0;
    endcase
  endfunction

  // One polynomial is 256*d bits, i.e. 4*d 64-bit words.
  function automatic logic [7:0] words_per_poly(input logic [3:0] d);
    words_per_poly = {2'b00, d, 2'b00};
  endfunction

endpackage

// File: rtl/decompress_round.sv
// Kyber Decompress_d: rounded scale by q/2^d for d < 12, plain mod-q reduce for d = 12.
module decompress_round
  import kyber_pkg::*;
(
  input  logic [11:0] i_raw,
  input  logic [3:0]  i_d,
  output logic [11:0] o_y
);

  logic [22:0] w_prod;
  logic [22:0] w_round;
  logic [22:0] w_scaled;

  always_comb begin
    w_prod   = {11'd0, i_raw} * 23'(KYBER_Q);
    w_round  = (i_d == 4'd0) ? 23'd0 : (23'd1 << (i_d - 4'd1));
    w_scaled = (w_prod + w_round) >> i_d;
    if (i_d == 4'd12) begin
      o_y = (i_raw >= 12'(KYBER_Q)) ? (i_raw - 12'(KYBER_Q)) : i_raw;
    end else begin
      o_y = w_scaled[11:0];
    end
  end

endmodule

// File: rtl/coeff_unpack_decompress.sv
// Splits 64-bit packed words into d-bit fields, decompresses each and streams
// exactly 256 coefficients per polynomial with backpressure on both sides.
module coeff_unpack_decompress
  import kyber_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic [3:0]  i_l,
  input  logic [63:0] i_coeffs,
  input  logic        i_coeffs_valid,
  output logic        o_coeffs_ready,
  output logic [11:0] o_coeff,
  output logic        o_coeff_valid,
  input  logic        i_coeff_ready,
  output logic [7:0]  o_idx,
  output logic        o_busy,
  output logic        o_done
);

  unpack_state_e r_state, w_state_nx;

  logic [3:0]   r_d;
  logic [127:0] r_buf;
  logic [7:0]   r_fill;
  logic [7:0]   r_words_in;
  logic [8:0]   r_coeffs_out;
  logic [11:0]  r_coeff;
  logic         r_coeff_valid;
  logic [7:0]   r_idx;

  logic         w_start;
  logic         w_run;
  logic         w_ready;
  logic         w_acc;
  logic         w_ext;
  logic         w_hs;
  logic [11:0]  w_mask;
  logic [11:0]  w_raw;
  logic [11:0]  w_y;
  logic [127:0] w_buf_sh;
  logic [7:0]   w_fill_sh;
  logic [127:0] w_buf_nx;
  logic [7:0]   w_fill_nx;

  always_comb begin
    w_run   = (r_state == S_RUN);
    w_start = (r_state == S_IDLE) && i_start && legal_d(i_l);
    w_ready = w_run && (r_fill <= 8'd64) && (r_words_in < words_per_poly(r_d));
    w_acc   = w_ready && i_coeffs_valid;
    w_hs    = r_coeff_valid && i_coeff_ready;
    w_ext   = w_run && (r_fill >= {4'd0, r_d}) && (!r_coeff_valid || i_coeff_ready)
              && (r_coeffs_out < 9'(KYBER_N));
    w_mask  = ~(12'hFFF << r_d);
    w_raw   = r_buf[11:0] & w_mask;
    // Extraction shifts first so a word accepted in the same cycle lands just above
    // the remaining valid bits.
    w_buf_sh  = w_ext ? (r_buf >> r_d) : r_buf;
    w_fill_sh = w_ext ? (r_fill - {4'd0, r_d}) : r_fill;
    w_buf_nx  = w_acc ? (w_buf_sh | ({64'd0, i_coeffs} << w_fill_sh)) : w_buf_sh;
    w_fill_nx = w_acc ? (w_fill_sh + 8'd64) : w_fill_sh;
  end

  decompress_round u_decompress_round (
    .i_raw (w_raw),
    .i_d   (r_d),
    .o_y   (w_y)
  );

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nx = S_RUN;
      S_RUN:   if (w_hs && (r_idx == 8'd255)) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_d           <= 4'd0;
      r_buf         <= 128'd0;
      r_fill        <= 8'd0;
      r_words_in    <= 8'd0;
      r_coeffs_out  <= 9'd0;
      r_coeff       <= 12'd0;
      r_coeff_valid <= 1'b0;
      r_idx         <= 8'd0;
    end else if (w_start) begin
      r_d          <= i_l;
      r_buf        <= 128'd0;
      r_fill       <= 8'd0;
      r_words_in   <= 8'd0;
      r_coeffs_out <= 9'd0;
    end else if (w_run) begin
      r_buf  <= w_buf_nx;
      r_fill <= w_fill_nx;
      if (w_acc) r_words_in <= r_words_in + 8'd1;
      if (w_ext) begin
        r_coeff       <= w_y;
        r_idx         <= r_coeffs_out[7:0];
        r_coeff_valid <= 1'b1;
        r_coeffs_out  <= r_coeffs_out + 9'd1;
      end else if (w_hs) begin
        r_coeff_valid <= 1'b0;
      end
    end
  end

  assign o_coeffs_ready = w_ready;
  assign o_coeff        = r_coeff;
  assign o_coeff_valid  = r_coeff_valid;
  assign o_idx          = r_idx;
  assign o_busy         = w_run;
  assign o_done         = (r_state == S_DONE);

endmodule

// File: tb/tb_coeff_unpack_decompress.sv
// Randomized scoreboard bench: a bit-level reference model fills an expected queue,
// a negedge monitor pops and compares on every output handshake.
module tb_coeff_unpack_decompress;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_start;
  logic [3:0]  i_l;
  logic [63:0] i_coeffs;
  logic        i_coeffs_valid;
  logic        o_coeffs_ready;
  logic [11:0] o_coeff;
  logic        o_coeff_valid;
  logic        i_coeff_ready;
  logic [7:0]  o_idx;
  logic        o_busy;
  logic        o_done;

  coeff_unpack_decompress dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_start        (i_start),
    .i_l            (i_l),
    .i_coeffs       (i_coeffs),
    .i_coeffs_valid (i_coeffs_valid),
    .o_coeffs_ready (o_coeffs_ready),
    .o_coeff        (o_coeff),
    .o_coeff_valid  (o_coeff_valid),
    .i_coeff_ready  (i_coeff_ready),
    .o_idx          (o_idx),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int c;
    int i;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] tw[48];
  int          tests = 0;
  int          fails = 0;
  int          hs_cnt = 0;
  bit          stall = 0;
  int          hold_c, hold_i;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int ref_dec(input int raw, input int d);
    if (d == 12) return raw % 3329;
    return (raw * 3329 + (1 << (d - 1))) >> d;
  endfunction

  // Monitor: compares every handshake against the scoreboard and checks stall stability.
  always @(negedge i_clk) begin
    if (!o_coeff_valid) begin
      stall = 0;
    end else begin
      if (stall) begin
        chk("stable_coeff", int'(o_coeff), hold_c);
        chk("stable_idx", int'(o_idx), hold_i);
      end
      if (i_coeff_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_output_queue_size", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("coeff[%0d]", e.i), int'(o_coeff), e.c);
          chk($sformatf("idx[%0d]", e.i), int'(o_idx), e.i);
        end
        hs_cnt++;
        stall = 0;
      end else begin
        stall  = 1;
        hold_c = int'(o_coeff);
        hold_i = int'(o_idx);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_coeff"}, int'(o_coeff), 0);
    chk({tag, "_coeff_valid"}, int'(o_coeff_valid), 0);
    chk({tag, "_coeffs_ready"}, int'(o_coeffs_ready), 0);
    chk({tag, "_idx"}, int'(o_idx), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_done"}, int'(o_done), 0);
  endtask

  // mode 0: ready always high, no input gaps; mode 1: random ready and valid gaps.
  task automatic run_poly(input int d, input int mode, input int abort_at);
    int nw = 4 * d;
    int wi = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit fin = 0;
    exp_q.delete();
    hs_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      int raw = 0;
      exp_t e;
      for (int j = 0; j < d; j++) begin
        int bp = k * d + j;
        if (tw[bp / 64][bp % 64]) raw += (1 << j);
      end
      e.c = ref_dec(raw, d);
      e.i = k;
      exp_q.push_back(e);
    end
    @(posedge i_clk); #1;
    i_l = 4'(d);
    i_start = 1'b1;
    i_coeff_ready = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk($sformatf("d%0d_busy_first", d), int'(o_busy), 1);
    chk($sformatf("d%0d_ready_first", d), int'(o_coeffs_ready), 1);
    while (!fin && cyc < 20000) begin
      @(negedge i_clk);
      if (wi >= nw) chk($sformatf("d%0d_ready_after_last", d), int'(o_coeffs_ready), 0);
      if (i_coeffs_valid && o_coeffs_ready) wi++;
      if (o_done) begin
        done_cnt++;
        chk($sformatf("d%0d_valid_at_done", d), int'(o_coeff_valid), 0);
        fin = 1;
      end
      @(posedge i_clk); #1;
      if (abort_at > 0 && hs_cnt >= abort_at) begin
        i_rstn = 1'b0;
        #1;
        check_reset_vals("midreset");
        exp_q.delete();
        i_coeffs_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        return;
      end
      i_coeffs_valid = (wi < nw) && (mode == 0 || $urandom_range(0, 3) != 0);
      i_coeffs = (wi < nw) ? tw[wi] : 64'd0;
      i_coeff_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc++;
    end
    chk($sformatf("d%0d_finished", d), int'(fin), 1);
    chk($sformatf("d%0d_done_pulses", d), done_cnt, 1);
    chk($sformatf("d%0d_handshakes", d), hs_cnt, 256);
    chk($sformatf("d%0d_leftover_expected", d), exp_q.size(), 0);
    chk($sformatf("d%0d_words_accepted", d), wi, nw);
    i_coeffs_valid = 1'b0;
    @(negedge i_clk);
    chk($sformatf("d%0d_done_low_after", d), int'(o_done), 0);
    chk($sformatf("d%0d_busy_low_after", d), int'(o_busy), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 48; i++) tw[i] = {$urandom(), $urandom()};
  endtask

  initial begin
    i_rstn = 1'b0;
    i_start = 1'b0;
    i_l = 4'd0;
    i_coeffs = 64'd0;
    i_coeffs_valid = 1'b0;
    i_coeff_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_vals("reset");
    i_rstn = 1'b1;

    // Illegal width: must stay idle.
    @(posedge i_clk); #1;
    i_l = 4'd7;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("illegal_busy", int'(o_busy), 0);
      chk("illegal_ready", int'(o_coeffs_ready), 0);
      chk("illegal_valid", int'(o_coeff_valid), 0);
      @(posedge i_clk); #1;
    end

    for (int i = 0; i < 48; i++) tw[i] = '1;
    run_poly(1, 0, 0);

    fill_random();
    tw[0] = 64'hFEDCBA9876543210;
    run_poly(4, 0, 0);

    for (int i = 0; i < 48; i++) tw[i] = '1;
    run_poly(11, 0, 0);

    fill_random();
    tw[0] = {16'($urandom()), 12'd0, 12'd4095, 12'd3329, 12'd3328};
    run_poly(12, 1, 0);

    fill_random();
    run_poly(10, 1, 0);

    fill_random();
    run_poly(5, 1, 100);
    fill_random();
    run_poly(5, 1, 0);

    fill_random();
    run_poly(12, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
